mem_stage: RTL

- MEMORY pipeline stage. It is the consumer of the EX/MEM latch fields produced by EXECUTE.
- Resolves the branch decision (pcsrc) and returns the branch target toward IF.
- Performs data-memory load/store against an internal word array with configurable access latency, stalling upstream as required.
- Registers results into the MEM/WB latch for the write-back stage.

---
 rtl/mem_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage: MEMORY pipeline stage.
//   Consumes the EX/MEM latch fields, resolves the branch decision, performs
//   data-memory loads/stores against an internal word array with LAT wait
//   cycles, and registers results into the MEM/WB latch.
//
// Parameters:
//   DEPTH  data-memory size in 32-bit words (power of two)
//   LAT    wait cycles per memory access (0..7); 0 = single-cycle memory
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   Defined   : a request with alu_result[1:0] != 0 does no access, does not
//               stall, and raises misalign on the next edge.
//   Undefined : misalign is tied to 0, low address bits are ignored.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wb_ctl                   EX/MEM write-back control {regwrite, memtoreg}
//   branch, zero             branch control and ALU zero flag
//   memread, memwrite        load / store request (both set = store)
//   EX_MEM_NPC               branch target from EXECUTE
//   alu_result               ALU result, byte address for loads/stores
//   rdata2                   store data
//   five_bit_muxout          destination register
//   pcsrc, branch_target     combinational branch decision / target
//   mem_stall                upstream must hold EX/MEM fields while high
//   mem_wb_ctlout, read_data, mem_alu_result, mem_write_reg   MEM/WB latch
//   misalign                 alignment fault flag
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ctl,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] EX_MEM_NPC,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        mem_stall,
  output logic [1:0]  mem_wb_ctlout,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_write_reg,
  output logic        misalign
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_ctl;
  logic [31:0] r_read_data;
  logic [31:0] r_alu;
  logic [4:0]  r_wreg;
  logic [31:0] r_mem [DEPTH];

  logic [AW-1:0] w_index;
  logic          w_req;
  logic          w_is_load;
  logic          w_fault;
  logic          w_complete;
  logic          w_unused;

  assign w_index   = alu_result[AW+1:2];
  assign w_req     = memread | memwrite;
  // Simultaneous read+write is treated as a store.
  assign w_is_load = memread & ~memwrite;

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misalign;
  assign w_fault  = (r_state == StIdle) & w_req & (alu_result[1:0] != 2'b00);
  assign misalign = r_misalign;
`else
  assign w_fault  = 1'b0;
  assign misalign = 1'b0;
`endif

  // Upper address bits are ignored (wrap modulo DEPTH); low bits only matter
  // when the alignment check is built in.
  assign w_unused = ^{alu_result[31:AW+2], alu_result[1:0]};

  // Edge on which the memory access actually takes effect.
  assign w_complete = ((r_state == StIdle) & w_req & ~w_fault & (LAT == 0)) |
                      ((r_state == StWait) & (r_cnt == 3'd0));

  // Combinational; forced low during reset so an aborted access releases
  // upstream immediately.
  assign mem_stall = ~rst &
                     (((r_state == StIdle) & w_req & ~w_fault & (LAT != 0)) |
                      ((r_state == StWait) & (r_cnt != 3'd0)));

  assign pcsrc         = branch & zero;
  assign branch_target = EX_MEM_NPC;

  assign mem_wb_ctlout  = r_ctl;
  assign read_data      = r_read_data;
  assign mem_alu_result = r_alu;
  assign mem_write_reg  = r_wreg;

  // Array is never reset; the rst guard keeps an edge seen during reset from
  // committing an aborted store.
  always_ff @(posedge clk) begin
    if (w_complete && memwrite && !rst) begin
      r_mem[w_index] <= rdata2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= 3'd0;
      r_ctl       <= 2'b00;
      r_read_data <= 32'd0;
      r_alu       <= 32'd0;
      r_wreg      <= 5'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_fault) begin
            r_ctl       <= 2'b00;
            r_read_data <= 32'd0;
            r_alu       <= alu_result;
            r_wreg      <= five_bit_muxout;
          end else if (!w_req || (LAT == 0)) begin
            r_ctl       <= wb_ctl;
            r_read_data <= w_is_load ? r_mem[w_index] : 32'd0;
            r_alu       <= alu_result;
            r_wreg      <= five_bit_muxout;
          end else begin
            // Start of a multi-cycle access: bubble, count remaining waits.
            r_state <= StWait;
            r_cnt   <= 3'(LAT - 1);
            r_ctl   <= 2'b00;
          end
        end
        StWait: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
            r_ctl <= 2'b00;
          end else begin
            r_state     <= StIdle;
            r_ctl       <= wb_ctl;
            r_read_data <= w_is_load ? r_mem[w_index] : 32'd0;
            r_alu       <= alu_result;
            r_wreg      <= five_bit_muxout;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_fault;
    end
  end
`endif

endmodule
